// File: rtl/control_signal.sv
// -----------------------------------------------------------------------------
// control_signal
//
// Timing/control generator for the frequency-meter counter chain. Running on
// the slow reference clock, it repeats a measurement frame forever:
//
//   CLEAR (CLEAR_LEN cycles) -> GATE (N cycles) -> LATCH (LATCH_LEN cycles)
//
// where N is GATE_LONG or GATE_SHORT, chosen by modeControl as the frame
// leaves CLEAR. A test mode (testMode=1) parks the machine in TEST, which
// keeps the counters counting and the result latches transparent. Leaving
// TEST always starts a fresh frame with a full CLEAR.
//
// Output decode (enable, clear, latch):
//   CLEAR (0,1,0)   GATE (1,0,0)   LATCH (0,0,1)   TEST (1,0,1)
//
// Ports
//   clkControl   in   1  reference clock; every flop uses its rising edge
//   rst_n        in   1  asynchronous, active-low reset
//   testMode     in   1  1 = continuous count/test mode, 0 = normal frames
//   modeControl  in   1  gate select: 0 = GATE_LONG, 1 = GATE_SHORT
//   enable       out  1  counter count-enable (gate window)
//   clear        out  1  counter synchronous clear request
//   latch        out  1  result-register load strobe
//
// All three outputs come straight from flops. They are loaded with the decode
// of next_state, so they always equal the decode of the current state while
// staying free of combinational glitches on their way to the counter chain.
// -----------------------------------------------------------------------------
module control_signal #(
  parameter int GATE_LONG  = 16,  // gate length when modeControl=0 (>=1)
  parameter int GATE_SHORT = 4,   // gate length when modeControl=1 (>=1)
  parameter int CLEAR_LEN  = 1,   // cycles clear is held per frame (>=1)
  parameter int LATCH_LEN  = 1    // cycles latch is held per frame (>=1)
) (
  input  logic clkControl,
  input  logic rst_n,
  input  logic testMode,
  input  logic modeControl,
  output logic enable,
  output logic clear,
  output logic latch
);

  // ---------------------------------------------------------------------------
  // Sizing
  // ---------------------------------------------------------------------------
  localparam int MAX_GATE = (GATE_LONG > GATE_SHORT) ? GATE_LONG : GATE_SHORT;
  localparam int MAX_FIX  = (CLEAR_LEN > LATCH_LEN)  ? CLEAR_LEN : LATCH_LEN;
  localparam int MAX_LEN  = (MAX_GATE > MAX_FIX)     ? MAX_GATE  : MAX_FIX;
  localparam int CW       = $clog2(MAX_LEN) + 1;

  // Terminal counts, pre-sized to the counter width.
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_LEN - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_LEN - 1);
  localparam logic [CW-1:0] LONG_LEN   = CW'(GATE_LONG);
  localparam logic [CW-1:0] SHORT_LEN  = CW'(GATE_SHORT);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_GATE  = 2'd1,
    S_LATCH = 2'd2,
    S_TEST  = 2'd3
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;        // cycles spent in the current state, minus one
  logic [CW-1:0] gate_len;   // gate length frozen for the running frame
  logic          gate_start; // this edge moves CLEAR -> GATE
  logic          enable_d;
  logic          clear_d;
  logic          latch_d;

  // ---------------------------------------------------------------------------
  // Process 1: state register, cycle counter, frozen gate length, outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written only with non-blocking (<=) assignments
  // so every flop samples the pre-edge values of the others, independent of
  // the order in which the simulator evaluates processes.
  always_ff @(posedge clkControl or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_CLEAR;
      cnt      <= '0;
      gate_len <= LONG_LEN;
      enable   <= 1'b0;
      clear    <= 1'b1;
      latch    <= 1'b0;
    end else begin
      state  <= next_state;
      enable <= enable_d;
      clear  <= clear_d;
      latch  <= latch_d;

      // Restart on every state change; otherwise count up, saturating so a
      // long stay in TEST can never wrap back onto a terminal count.
      if (next_state != state) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end

      // The gate length is captured once per frame. modeControl changes
      // during GATE therefore only take effect at the next CLEAR -> GATE.
      if (gate_start) begin
        gate_len <= modeControl ? SHORT_LEN : LONG_LEN;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb block receives a default
  // value first; a path that leaves one unassigned would infer a latch.
  always_comb begin
    next_state = state;
    gate_start = 1'b0;

    if (testMode) begin
      // Test mode wins from any state and abandons any partial frame.
      next_state = S_TEST;
    end else begin
      unique case (state)
        S_CLEAR: begin
          if (cnt == CLEAR_LAST) begin
            next_state = S_GATE;
            gate_start = 1'b1;
          end
        end
        S_GATE: begin
          // gate_len is only ever loaded with a value >= 1.
          if (cnt == (gate_len - CNT_ONE)) begin
            next_state = S_LATCH;
          end
        end
        S_LATCH: begin
          if (cnt == LATCH_LAST) begin
            next_state = S_CLEAR;
          end
        end
        S_TEST: begin
          // Leaving test mode always begins a fresh frame.
          next_state = S_CLEAR;
        end
        default: begin
          next_state = S_CLEAR;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Process 3: output decode
  // ---------------------------------------------------------------------------
  // Decoding next_state means the output flops load exactly the decode of the
  // state being entered, so clear and enable (and clear and latch) can never
  // be high together on the flop outputs.
  always_comb begin
    enable_d = 1'b0;
    clear_d  = 1'b0;
    latch_d  = 1'b0;
    unique case (next_state)
      S_CLEAR: clear_d  = 1'b1;
      S_GATE:  enable_d = 1'b1;
      S_LATCH: latch_d  = 1'b1;
      S_TEST: begin
        enable_d = 1'b1;
        latch_d  = 1'b1;
      end
      default: clear_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_control_signal.sv
// -----------------------------------------------------------------------------
// tb_control_signal
//
// Bench for control_signal with default parameters (GATE_LONG=16,
// GATE_SHORT=4, CLEAR_LEN=1, LATCH_LEN=1). Inputs are driven on the falling
// edge; outputs are compared 1 ns after the rising edge. Expected values are
// written as {enable, clear, latch}.
// -----------------------------------------------------------------------------
module tb_control_signal;

  logic clkControl;
  logic rst_n;
  logic testMode;
  logic modeControl;
  logic enable;
  logic clear;
  logic latch;

  control_signal dut (
    .clkControl  (clkControl),
    .rst_n       (rst_n),
    .testMode    (testMode),
    .modeControl (modeControl),
    .enable      (enable),
    .clear       (clear),
    .latch       (latch)
  );

  initial clkControl = 1'b0;
  always #5 clkControl = ~clkControl;

  // Output patterns {enable, clear, latch}
  localparam logic [2:0] O_CLEAR = 3'b010;
  localparam logic [2:0] O_GATE  = 3'b100;
  localparam logic [2:0] O_LATCH = 3'b001;
  localparam logic [2:0] O_TEST  = 3'b101;

  typedef struct {
    logic       rst_n;
    logic       tm;
    logic       mc;
    logic [2:0] exp;
  } vec_t;

  localparam int MAX_VEC = 400;
  vec_t vecs [MAX_VEC];
  int   nvec;

  int checks;
  int errors;

  task automatic check(input string name, input logic [2:0] act,
                       input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function void add(input logic r, input logic tm, input logic mc,
                    input logic [2:0] exp);
    if (nvec < MAX_VEC) begin
      vecs[nvec].rst_n = r;
      vecs[nvec].tm    = tm;
      vecs[nvec].mc    = mc;
      vecs[nvec].exp   = exp;
      nvec++;
    end
  endfunction

  // n gate cycles with modeControl held at mc
  function void add_gate(input int n, input logic mc);
    for (int i = 0; i < n; i++) add(1'b1, 1'b0, mc, O_GATE);
  endfunction

  function void add_tail(input logic mc);
    add(1'b1, 1'b0, mc, O_LATCH);
    add(1'b1, 1'b0, mc, O_CLEAR);
  endfunction

  logic [2:0] outs;
  assign outs = {enable, clear, latch};

  initial begin
    checks      = 0;
    errors      = 0;
    nvec        = 0;
    rst_n       = 1'b0;
    testMode    = 1'b0;
    modeControl = 1'b0;

    // ---- build the vector table -------------------------------------------
    // Reset held 3 cycles: CLEAR decode throughout.
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b0, O_CLEAR);
    // Two long frames: 16 gate, 1 latch, 1 clear (period 18).
    for (int f = 0; f < 2; f++) begin
      add_gate(16, 1'b0);
      add_tail(1'b0);
    end
    // Reset again, then short frames (period 6).
    add(1'b0, 1'b0, 1'b1, O_CLEAR);
    for (int f = 0; f < 2; f++) begin
      add_gate(4, 1'b1);
      add_tail(1'b1);
    end
    // Short gate, modeControl drops mid-gate: gate stays 4 long.
    add_gate(2, 1'b1);
    add_gate(2, 1'b0);
    add_tail(1'b0);
    // Next frame picks up the long gate; modeControl rises mid-gate.
    add_gate(8, 1'b0);
    add_gate(8, 1'b1);
    add_tail(1'b1);
    // Next frame is short.
    add_gate(4, 1'b1);
    add_tail(1'b0);
    // Long gate interrupted by 50 cycles of test mode.
    add_gate(5, 1'b0);
    for (int i = 0; i < 50; i++) add(1'b1, 1'b1, 1'b0, O_TEST);
    // Release: one clear, then a full long gate.
    add(1'b1, 1'b0, 1'b0, O_CLEAR);
    add_gate(16, 1'b0);
    add_tail(1'b0);
    // Test mode entered straight from CLEAR, released after 2 cycles.
    add(1'b1, 1'b1, 1'b1, O_TEST);
    add(1'b1, 1'b1, 1'b1, O_TEST);
    add(1'b1, 1'b0, 1'b1, O_CLEAR);
    add_gate(4, 1'b1);
    add_tail(1'b1);

    // ---- apply the table ----------------------------------------------------
    for (int i = 0; i < nvec; i++) begin
      @(negedge clkControl);
      rst_n       = vecs[i].rst_n;
      testMode    = vecs[i].tm;
      modeControl = vecs[i].mc;
      @(posedge clkControl);
      #1;
      check($sformatf("vec%0d", i), outs, vecs[i].exp);
    end

    // ---- asynchronous reset mid-gate --------------------------------------
    @(negedge clkControl);
    rst_n       = 1'b0;
    testMode    = 1'b0;
    modeControl = 1'b0;
    @(negedge clkControl);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) @(posedge clkControl);
    #2;
    check("async_pre_gate", outs, O_GATE);
    rst_n = 1'b0;                  // between edges
    #1;
    check("async_reset_now", outs, O_CLEAR);
    @(negedge clkControl);
    rst_n = 1'b1;
    @(posedge clkControl);
    #1;
    check("async_after_release", outs, O_GATE);

    // ---- long run with invariant checks -----------------------------------
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clkControl);
      testMode    = ((cyc / 50) % 2) == 1;
      modeControl = ((cyc / 100) % 2) == 1;
      @(posedge clkControl);
      #1;
      check("clear_and_latch", {2'b00, clear & latch}, 3'b000);
      check("clear_and_enable", {2'b00, clear & enable}, 3'b000);
      if (testMode) check("stress_test_state", outs, O_TEST);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
